// File: rtl/eth_icmp_unreach_gen.sv
// ICMPv4 Destination-Unreachable generator. It builds a 70-byte frame that quotes the
// offending IP+UDP header and streams it as nine 64-bit AXI-Stream beats.
module eth_icmp_unreach_gen #(
    parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [31:0] SRC_IP    = 32'hC0A8_0001,
    parameter logic [7:0]  ICMP_CODE = 8'h0a,
    parameter logic [7:0]  IP_TTL    = 8'd64
) (
    input  logic         clk156,
    input  logic         eth_rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [47:0]  req_dst_mac,
    input  logic [223:0] req_orig,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [63:0]  m_axis_tdata,
    output logic [7:0]   m_axis_tkeep,
    output logic         m_axis_tlast,
    output logic         m_axis_tuser,
    output logic [15:0]  pkt_cnt
);

    typedef enum logic [1:0] {IDLE, CSUM1, CSUM2, SEND} state_t;

    state_t         state_reg, state_next;
    logic [3:0]     beat_reg, beat_next;
    logic [47:0]    dst_mac_reg;
    logic [223:0]   orig_reg;
    logic [15:0]    ip_id_reg;
    logic [15:0]    pkt_cnt_reg;
    logic [31:0]    ip_sum_reg, ip_sum_next;
    logic [31:0]    icmp_sum_reg, icmp_sum_next;
    logic [15:0]    ip_csum_reg, icmp_csum_reg;
    logic [15:0]    orig_word [14];
    logic [31:0]    dst_ip;
    logic [7:0]     frame [72];
    logic [6:0]     beat_base;
    logic           req_fire;
    logic           pkt_done;

    // Two end-around folds are enough to absorb every carry of a 32-bit partial sum.
    function automatic logic [15:0] csum_fold(input logic [31:0] s);
        logic [31:0] t;
        t = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
        t = {16'h0000, t[15:0]} + {16'h0000, t[31:16]};
        return ~t[15:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 14; gi++) begin : g_orig_word
            assign orig_word[gi] = {orig_reg[16*gi +: 8], orig_reg[16*gi+8 +: 8]};
        end
    endgenerate

    // The quoted datagram's source address (bytes 12-15) is where the reply goes.
    assign dst_ip = {orig_reg[103:96], orig_reg[111:104], orig_reg[119:112], orig_reg[127:120]};

    always_comb begin
        ip_sum_next = 32'h0000_4500 + 32'h0000_0038 + {16'h0000, ip_id_reg}
                    + {16'h0000, IP_TTL, 8'h01}
                    + {16'h0000, SRC_IP[31:16]} + {16'h0000, SRC_IP[15:0]}
                    + {16'h0000, dst_ip[31:16]} + {16'h0000, dst_ip[15:0]};
        icmp_sum_next = {16'h0000, 8'h03, ICMP_CODE};
        for (int i = 0; i < 14; i++) begin
            icmp_sum_next = icmp_sum_next + {16'h0000, orig_word[i]};
        end
    end

    always_comb begin
        state_next    = state_reg;
        beat_next     = beat_reg;
        req_ready     = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = CSUM1;
                end
            end
            CSUM1: state_next = CSUM2;
            CSUM2: begin
                state_next = SEND;
                beat_next  = 4'd0;
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    if (beat_reg == 4'd8) begin
                        state_next = IDLE;
                    end else begin
                        beat_next = beat_reg + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_fire = (state_reg == IDLE) && req_valid;
    assign pkt_done = (state_reg == SEND) && m_axis_tready && (beat_reg == 4'd8);

    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            state_reg <= IDLE;
            beat_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
        end
    end

    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            dst_mac_reg   <= '0;
            orig_reg      <= '0;
            ip_id_reg     <= '0;
            pkt_cnt_reg   <= '0;
            ip_sum_reg    <= '0;
            icmp_sum_reg  <= '0;
            ip_csum_reg   <= '0;
            icmp_csum_reg <= '0;
        end else begin
            if (req_fire) begin
                dst_mac_reg <= req_dst_mac;
                orig_reg    <= req_orig;
            end
            if (state_reg == CSUM1) begin
                ip_sum_reg   <= ip_sum_next;
                icmp_sum_reg <= icmp_sum_next;
            end
            if (state_reg == CSUM2) begin
                ip_csum_reg   <= csum_fold(ip_sum_reg);
                icmp_csum_reg <= csum_fold(icmp_sum_reg);
            end
            if (pkt_done) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
                ip_id_reg   <= ip_id_reg + 16'd1;
            end
        end
    end

    // Whole frame as a byte map. Bytes 70-71 stay zero so the tail of beat 8 is clean.
    always_comb begin
        for (int k = 0; k < 72; k++) begin
            frame[k] = 8'h00;
        end
        for (int k = 0; k < 6; k++) begin
            frame[k]     = dst_mac_reg[47-8*k -: 8];
            frame[6 + k] = SRC_MAC[47-8*k -: 8];
        end
        frame[12] = 8'h08;
        frame[14] = 8'h45;
        frame[17] = 8'h38;
        frame[18] = ip_id_reg[15:8];
        frame[19] = ip_id_reg[7:0];
        frame[22] = IP_TTL;
        frame[23] = 8'h01;
        frame[24] = ip_csum_reg[15:8];
        frame[25] = ip_csum_reg[7:0];
        for (int k = 0; k < 4; k++) begin
            frame[26 + k] = SRC_IP[31-8*k -: 8];
            frame[30 + k] = dst_ip[31-8*k -: 8];
        end
        frame[34] = 8'h03;
        frame[35] = ICMP_CODE;
        frame[36] = icmp_csum_reg[15:8];
        frame[37] = icmp_csum_reg[7:0];
        for (int k = 0; k < 28; k++) begin
            frame[42 + k] = orig_reg[8*k +: 8];
        end
    end

    assign beat_base = {beat_reg, 3'b000};

    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign m_axis_tdata[8*gi +: 8] = (state_reg == SEND) ? frame[beat_base + 7'(gi)] : 8'h00;
        end
    endgenerate

    assign m_axis_tkeep = (state_reg != SEND) ? 8'h00 : ((beat_reg == 4'd8) ? 8'h3F : 8'hFF);
    assign m_axis_tlast = (state_reg == SEND) && (beat_reg == 4'd8);
    assign m_axis_tuser = 1'b0;
    assign pkt_cnt      = pkt_cnt_reg;

endmodule

// File: tb/tb_eth_icmp_unreach_gen.sv
// Bench for eth_icmp_unreach_gen: fixed-vector beat checks, randomized packets against a
// byte-level frame model, stall stability, busy back-pressure, mid-packet reset and wrap.
module tb_eth_icmp_unreach_gen;

    localparam logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01;
    localparam logic [31:0] SRC_IP    = 32'hC0A8_0001;
    localparam logic [7:0]  ICMP_CODE = 8'h0a;
    localparam logic [7:0]  IP_TTL    = 8'd64;

    logic         clk156 = 1'b0;
    logic         eth_rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [47:0]  req_dst_mac = '0;
    logic [223:0] req_orig = '0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic         m_axis_tlast;
    logic         m_axis_tuser;
    logic [15:0]  pkt_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_id = 16'h0000;
    logic [15:0] exp_cnt = 16'h0000;
    logic [63:0] cap_data [9];
    logic [7:0]  cap_keep [9];
    logic        cap_last [9];

    typedef struct {
        int          beat;
        logic [63:0] mask;
        logic [63:0] val;
        logic [7:0]  keep;
        logic        last;
    } vec_t;
    vec_t vecs [7];

    always #5 clk156 = ~clk156;

    eth_icmp_unreach_gen #(
        .SRC_MAC(SRC_MAC), .SRC_IP(SRC_IP), .ICMP_CODE(ICMP_CODE), .IP_TTL(IP_TTL)
    ) dut (
        .clk156(clk156), .eth_rst(eth_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dst_mac(req_dst_mac), .req_orig(req_orig),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .pkt_cnt(pkt_cnt)
    );

    task automatic chk(input string name, input logic [559:0] act, input logic [559:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Folded (non-inverted) ones-complement sum of big-endian words over bytes [lo, hi).
    function automatic logic [15:0] ocsum(input logic [559:0] f, input int lo, input int hi);
        int unsigned s;
        s = 0;
        for (int i = lo; i < hi; i += 2) begin
            s = s + {16'h0000, f[8*i +: 8], f[8*i+8 +: 8]};
        end
        while (s > 32'h0000_FFFF) begin
            s = (s & 32'h0000_FFFF) + (s >> 16);
        end
        return s[15:0];
    endfunction

    function automatic logic [559:0] model_frame(input logic [47:0] mac, input logic [223:0] orig,
                                                 input logic [15:0] id);
        logic [559:0] f;
        logic [15:0]  c;
        f = '0;
        for (int k = 0; k < 6; k++) begin
            f[8*k +: 8]       = mac[8*(5-k) +: 8];
            f[8*(6+k) +: 8]   = SRC_MAC[8*(5-k) +: 8];
        end
        f[8*12 +: 8] = 8'h08;
        f[8*14 +: 8] = 8'h45;
        f[8*17 +: 8] = 8'd56;
        f[8*18 +: 8] = id[15:8];
        f[8*19 +: 8] = id[7:0];
        f[8*22 +: 8] = IP_TTL;
        f[8*23 +: 8] = 8'h01;
        for (int k = 0; k < 4; k++) begin
            f[8*(26+k) +: 8] = SRC_IP[8*(3-k) +: 8];
            f[8*(30+k) +: 8] = orig[8*(12+k) +: 8];
        end
        f[8*34 +: 8] = 8'h03;
        f[8*35 +: 8] = ICMP_CODE;
        for (int k = 0; k < 28; k++) begin
            f[8*(42+k) +: 8] = orig[8*k +: 8];
        end
        c = ~ocsum(f, 14, 34);
        f[8*24 +: 8] = c[15:8];
        f[8*25 +: 8] = c[7:0];
        c = ~ocsum(f, 34, 70);
        f[8*36 +: 8] = c[15:8];
        f[8*37 +: 8] = c[7:0];
        return f;
    endfunction

    // Clears the id and checksum bytes, which legitimately differ between two sends.
    function automatic logic [559:0] strip_id(input logic [559:0] f);
        logic [559:0] r;
        r = f;
        r[8*18 +: 16] = '0;
        r[8*24 +: 16] = '0;
        r[8*36 +: 16] = '0;
        return r;
    endfunction

    task automatic do_req(input logic [47:0] mac, input logic [223:0] orig);
        int n;
        n = 0;
        @(negedge clk156);
        req_valid   = 1'b1;
        req_dst_mac = mac;
        req_orig    = orig;
        while (!req_ready && n < 100) begin
            @(negedge clk156);
            n++;
        end
        chk("req_accept", req_ready, 1'b1);
        @(negedge clk156);
        req_valid = 1'b0;
    endtask

    task automatic collect(input bit stall, output logic [559:0] fr, output int lat);
        int nb, guard;
        bit done, stalled;
        logic [63:0] sd;
        logic [7:0]  sk;
        logic        sl;
        fr = '0; lat = 0; nb = 0; guard = 0; done = 0; stalled = 0;
        sd = '0; sk = '0; sl = 1'b0;
        while (!m_axis_tvalid && lat < 50) begin
            chk("ready_busy_wait", req_ready, 1'b0);
            @(negedge clk156);
            lat++;
        end
        if (!m_axis_tvalid) begin
            chk("first_beat_timeout", m_axis_tvalid, 1'b1);
            return;
        end
        while (!done && guard < 400) begin
            if (stalled) begin
                chk("stall_stable", {sd, sk, sl}, {m_axis_tdata, m_axis_tkeep, m_axis_tlast});
            end
            chk("tvalid_in_pkt", m_axis_tvalid, 1'b1);
            chk("ready_busy_send", req_ready, 1'b0);
            m_axis_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tready) begin
                cap_data[nb] = m_axis_tdata;
                cap_keep[nb] = m_axis_tkeep;
                cap_last[nb] = m_axis_tlast;
                chk("tkeep", m_axis_tkeep, (nb == 8) ? 8'h3F : 8'hFF);
                chk("tlast", m_axis_tlast, (nb == 8));
                for (int j = 0; j < 8; j++) begin
                    if (nb*8 + j < 70) fr[8*(nb*8+j) +: 8] = m_axis_tdata[8*j +: 8];
                end
                if (m_axis_tlast || nb == 8) done = 1;
                nb++;
                stalled = 0;
            end else begin
                stalled = 1;
                sd = m_axis_tdata; sk = m_axis_tkeep; sl = m_axis_tlast;
            end
            @(negedge clk156);
            guard++;
        end
        m_axis_tready = 1'b1;
        chk("pkt_complete", done, 1'b1);
    endtask

    task automatic run_pkt(input logic [47:0] mac, input logic [223:0] orig, input bit stall,
                           output logic [559:0] fr);
        int lat;
        do_req(mac, orig);
        collect(stall, fr, lat);
        chk("latency", lat, 2);
        chk("frame", fr, model_frame(mac, orig, exp_id));
        chk("ip_sum", ocsum(fr, 14, 34), 16'hFFFF);
        chk("icmp_sum", ocsum(fr, 34, 70), 16'hFFFF);
        exp_id  = exp_id + 16'd1;
        exp_cnt = exp_cnt + 16'd1;
        chk("pkt_cnt", pkt_cnt, exp_cnt);
        $display("pkt id=%h cnt=%0d stall=%0d lat=%0d", exp_id - 16'd1, pkt_cnt, stall, lat);
    endtask

    task automatic apply_reset();
        @(negedge clk156);
        eth_rst = 1'b1;
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
        chk("rst_cnt", pkt_cnt, 16'h0000);
        repeat (2) @(negedge clk156);
        eth_rst = 1'b0;
        exp_id  = 16'h0000;
        exp_cnt = 16'h0000;
    endtask

    initial begin
        logic [223:0] orig;
        logic [47:0]  mac;
        logic [559:0] f1, f2;
        int           lat, n;

        vecs[0] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0002_FFEE_DDCC_BBAA, 8'hFF, 1'b0};
        vecs[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0045_0008_0100_0000, 8'hFF, 1'b0};
        vecs[2] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0140_0000_0000_3800, 8'hFF, 1'b0};
        vecs[3] = '{3, 64'hFFFF_FFFF_FFFF_0000, 64'h000A_0100_A8C0_0000, 8'hFF, 1'b0};
        vecs[4] = '{4, 64'hFFFF_0000_FFFF_FFFF, 64'h0000_0000_0A03_0500, 8'hFF, 1'b0};
        vecs[5] = '{5, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 8'hFF, 1'b0};
        vecs[6] = '{8, 64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_0000, 8'h3F, 1'b1};

        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tuser}, '0);
        chk("rst_cnt", pkt_cnt, 16'h0000);
        repeat (2) @(negedge clk156);
        eth_rst = 1'b0;

        // Single request with known fields.
        for (int k = 0; k < 28; k++) orig[8*k +: 8] = 8'(3*k + 1);
        orig[8*12 +: 32] = {8'h05, 8'h00, 8'h00, 8'h0A};
        orig[8*16 +: 32] = {8'h01, 8'h00, 8'hA8, 8'hC0};
        orig[8*20 +: 16] = {8'h35, 8'h00};
        run_pkt(48'hAABB_CCDD_EEFF, orig, 1'b0, f1);
        for (int v = 0; v < 7; v++) begin
            chk($sformatf("vec%0d_data", v), cap_data[vecs[v].beat] & vecs[v].mask, vecs[v].val);
            chk($sformatf("vec%0d_keep", v), cap_keep[vecs[v].beat], vecs[v].keep);
            chk($sformatf("vec%0d_last", v), cap_last[vecs[v].beat], vecs[v].last);
        end
        chk("single_cnt", pkt_cnt, 16'd1);

        // Same request without and with back-pressure.
        run_pkt(48'h1122_3344_5566, orig, 1'b0, f1);
        run_pkt(48'h1122_3344_5566, orig, 1'b1, f2);
        chk("stall_same_bytes", strip_id(f2), strip_id(f1));

        for (int p = 0; p < 1000; p++) begin
            mac = {16'($urandom), $urandom};
            for (int w = 0; w < 7; w++) orig[32*w +: 32] = $urandom;
            run_pkt(mac, orig, 1'($urandom_range(0, 1)), f1);
        end

        // Reset while beat 4 is on the bus.
        do_req(48'hA1A2_A3A4_A5A6, orig);
        n = 0;
        while (!m_axis_tvalid && n < 10) begin
            @(negedge clk156);
            n++;
        end
        m_axis_tready = 1'b1;
        repeat (4) @(negedge clk156);
        eth_rst = 1'b1;
        #1;
        chk("midrst_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst_cnt", pkt_cnt, 16'h0000);
        @(negedge clk156);
        eth_rst = 1'b0;
        exp_id  = 16'h0000;
        exp_cnt = 16'h0000;
        repeat (3) begin
            @(negedge clk156);
            chk("postrst_tvalid", m_axis_tvalid, 1'b0);
            chk("postrst_ready", req_ready, 1'b1);
        end
        run_pkt(48'hA1A2_A3A4_A5A6, orig, 1'b0, f1);

        // Second request held during SEND is accepted only after IDLE returns.
        apply_reset();
        do_req(48'hB1B2_B3B4_B5B6, orig);
        req_valid   = 1'b1;
        req_dst_mac = 48'hC1C2_C3C4_C5C6;
        collect(1'b0, f1, lat);
        chk("busy_a_frame", f1, model_frame(48'hB1B2_B3B4_B5B6, orig, 16'h0000));
        chk("busy_idle_ready", req_ready, 1'b1);
        @(negedge clk156);
        req_valid = 1'b0;
        collect(1'b0, f2, lat);
        chk("busy_b_latency", lat + 1, 3);
        chk("busy_b_frame", f2, model_frame(48'hC1C2_C3C4_C5C6, orig, 16'h0001));
        chk("busy_cnt", pkt_cnt, 16'd2);
        exp_id  = 16'h0002;
        exp_cnt = 16'h0002;

        // Counter wrap.
        @(negedge clk156);
        force dut.ip_id_reg   = 16'hFFFF;
        force dut.pkt_cnt_reg = 16'hFFFF;
        #1;
        release dut.ip_id_reg;
        release dut.pkt_cnt_reg;
        exp_id  = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        @(negedge clk156);
        chk("wrap_preload", pkt_cnt, 16'hFFFF);
        run_pkt(48'hD1D2_D3D4_D5D6, orig, 1'b0, f1);
        chk("wrap_id_ffff", {f1[8*18 +: 8], f1[8*19 +: 8]}, 16'hFFFF);
        chk("wrap_cnt_zero", pkt_cnt, 16'h0000);
        run_pkt(48'hD1D2_D3D4_D5D6, orig, 1'b1, f1);
        chk("wrap_id_0000", {f1[8*18 +: 8], f1[8*19 +: 8]}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
